// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: FSM state encoding,
// parameter defaults and the latched request record.
package data_mem_responder_pkg;

  localparam int DEPTH_WORDS_DEF = 256;
  localparam int WAIT_CYCLES_DEF = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

endpackage

// File: rtl/data_mem_responder_bank.sv
// dmem_bank: byte-enabled synchronous single-port RAM, read-first, with
// one 32-bit word per index. Contents are deliberately left unreset.
module dmem_bank
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read returns the word as it stood before any write on the same edge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one CPU load/store at a time, waits
// WAIT_CYCLES, then pulses a one-cycle response. Define DMEM_ERR_EN to
// enable misaligned/out-of-range fault reporting on resp_err.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  dmem_req_t   in_req;
  dmem_req_t   lat;
  dmem_req_t   cur;
  logic        accept;
  logic        enter_resp;
  logic        cur_fault;
  logic        bank_we;
  logic [31:0] bank_rdata;
  logic [31:0] rdata_now;
  logic [31:0] rdata_hold;
  logic        unused_addr_bits;

  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    in_req.we    = req_we;
    in_req.addr  = req_addr;
    in_req.wdata = req_wdata;
    in_req.be    = req_be;
  end

  // With zero wait states RESP is entered on the acceptance edge itself,
  // before the latch holds the request, so IDLE looks at the live inputs.
  assign cur = (state == ST_IDLE) ? in_req : lat;

  assign enter_resp = ((state == ST_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state == ST_WAIT) && (cnt == 4'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            cnt   <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat <= '0;
    end else if (accept) begin
      lat <= in_req;
    end
  end

`ifdef DMEM_ERR_EN
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  assign cur_fault = (cur.addr[1:0] != 2'b00) || (cur.addr >= ADDR_LIMIT);
`else
  assign cur_fault = 1'b0;
`endif

  assign unused_addr_bits = ^{cur.addr[31:AW+2], cur.addr[1:0]};

  // A store commits only on the RESP-entry edge, so a reset during WAIT
  // discards it cleanly.
  assign bank_we = enter_resp && cur.we && !cur_fault;

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .be   (cur.be),
    .idx  (cur.addr[AW+1:2]),
    .wdata(cur.wdata),
    .rdata(bank_rdata)
  );

  assign rdata_now  = (!cur.we && !cur_fault) ? bank_rdata : 32'd0;
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = (state == ST_RESP) && cur_fault;
  assign resp_rdata = (state == ST_RESP) ? rdata_now : rdata_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_hold <= 32'd0;
    end else if (state == ST_RESP) begin
      rdata_hold <= rdata_now;
    end
  end

endmodule
